// File: rtl/bundle_fetch_queue.sv
// bundle_fetch_queue: VLIW bundle fetch and dispatch front end.
// Keeps one MMU fetch in flight, buffers up to DEPTH bundles in a circular
// queue and dispatches one bundle at a time when every FU is idle.
// Optional macro FETCH_PERF_EN adds the perfStarveCount output.
module bundle_fetch_queue #(
   parameter int unsigned NFU      = 2,
   parameter int unsigned DEPTH    = 4,
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic [63:0]                fetchAddress,
   output logic                       fetchRequest,
   input  logic                       fetchDone,
   input  logic [NFU*32-1:0]          fetchData,
   input  logic                       redirectValid,
   input  logic [63:0]                redirectTarget,
   input  logic [NFU-1:0]             fuWorking,
   output logic [NFU*32-1:0]          instruction,
   output logic [63:0]                bundleAddr,
   output logic                       instructionReady,
   output logic [$clog2(DEPTH+1)-1:0] queueCount
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]                perfStarveCount
`endif
);
   localparam int unsigned BW = NFU * 32;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned AW = $clog2(NFU * 4);
   localparam logic [63:0]   STEP       = 64'(NFU * 4);
   localparam logic [63:0]   ALIGN_MASK = ~((64'd1 << AW) - 64'd1);
   localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);

   typedef enum logic {S_IDLE, S_WAIT} state_t;
   state_t r_state, w_nextState;

   logic [BW-1:0] r_qData [DEPTH];
   logic [63:0]   r_qAddr [DEPTH];
   logic [PW-1:0] r_rdPtr, r_wrPtr;
   logic [CW-1:0] r_count;

   logic [63:0]   r_fetchPc, r_fetchAddress;
   logic          r_fetchRequest, r_discard, r_holdoff, r_instrReady;
   logic [BW-1:0] r_instruction;
   logic [63:0]   r_bundleAddr;

   logic w_issue, w_push, w_pop, w_setDiscard, w_clrDiscard;

   function automatic logic [PW-1:0] f_nextPtr(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   // Dispatch when the queue holds a bundle, all FUs idle, no holdoff, no redirect
   assign w_pop = (r_count != '0) && (fuWorking == '0) && !r_holdoff && !redirectValid;

   // Fetch FSM next-state: issue from IDLE when a slot is free, complete/drop in WAIT
   always_comb begin
      w_nextState  = r_state;
      w_issue      = 1'b0;
      w_push       = 1'b0;
      w_setDiscard = 1'b0;
      w_clrDiscard = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!redirectValid && (r_count < FULL_CNT)) begin
               w_issue     = 1'b1;
               w_nextState = S_WAIT;
            end
         end
         S_WAIT: begin
            if (fetchDone) begin
               // A response coinciding with a redirect is stale and dropped outright
               w_nextState  = S_IDLE;
               w_clrDiscard = 1'b1;
               w_push       = !r_discard && !redirectValid;
            end else if (redirectValid) begin
               w_setDiscard = 1'b1;
            end
         end
         default: w_nextState = S_IDLE;
      endcase
   end

   // Fetch FSM state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_nextState;
   end

   // Fetch PC, MMU request strobe/address and stale-response discard flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetchPc      <= RESET_PC;
         r_fetchAddress <= RESET_PC;
         r_fetchRequest <= 1'b0;
         r_discard      <= 1'b0;
      end else begin
         r_fetchRequest <= w_issue;
         if (w_issue) r_fetchAddress <= r_fetchPc;
         if (redirectValid)  r_fetchPc <= redirectTarget & ALIGN_MASK;
         else if (w_push)    r_fetchPc <= r_fetchPc + STEP;
         if (w_setDiscard)      r_discard <= 1'b1;
         else if (w_clrDiscard) r_discard <= 1'b0;
      end
   end

   // Queue pointers and occupancy; redirect flushes everything
   always_ff @(posedge clk) begin
      if (rst || redirectValid) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wrPtr <= f_nextPtr(r_wrPtr);
         if (w_pop)  r_rdPtr <= f_nextPtr(r_rdPtr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Queue storage write (no reset needed, validity tracked by pointers)
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_qData[r_wrPtr] <= fetchData;
         r_qAddr[r_wrPtr] <= r_fetchAddress;
      end
   end

   // Dispatch register: latch head bundle, pulse ready, one-cycle holdoff
   always_ff @(posedge clk) begin
      if (rst) begin
         r_instruction <= '0;
         r_bundleAddr  <= '0;
         r_instrReady  <= 1'b0;
         r_holdoff     <= 1'b0;
      end else begin
         r_instrReady <= w_pop;
         r_holdoff    <= w_pop;
         if (w_pop) begin
            r_instruction <= r_qData[r_rdPtr];
            r_bundleAddr  <= r_qAddr[r_rdPtr];
         end
      end
   end

   assign fetchAddress     = r_fetchAddress;
   assign fetchRequest     = r_fetchRequest;
   assign instruction      = r_instruction;
   assign bundleAddr       = r_bundleAddr;
   assign instructionReady = r_instrReady;
   assign queueCount       = r_count;

`ifdef FETCH_PERF_EN
   logic [31:0] r_perfStarve;

   // Saturating count of cycles with an empty queue and idle FUs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_perfStarve <= '0;
      end else if ((r_count == '0) && (fuWorking == '0) && (r_perfStarve != '1)) begin
         r_perfStarve <= r_perfStarve + 32'd1;
      end
   end

   assign perfStarveCount = r_perfStarve;
`endif

endmodule

// File: tb/tb_bundle_fetch_queue.sv
// Directed testbench for bundle_fetch_queue with an MMU model and a
// scoreboard of expected dispatches (address; data derived from address).
module tb_bundle_fetch_queue;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [63:0]  fetchAddress;
   logic         fetchRequest;
   logic         fetchDone = 1'b0;
   logic [63:0]  fetchData = '0;
   logic         redirectValid = 1'b0;
   logic [63:0]  redirectTarget = '0;
   logic [1:0]   fuWorking = 2'b00;
   logic [63:0]  instruction;
   logic [63:0]  bundleAddr;
   logic         instructionReady;
   logic [2:0]   queueCount;
`ifdef FETCH_PERF_EN
   logic [31:0]  perfStarveCount;
`endif

   bundle_fetch_queue #(.NFU(2), .DEPTH(4), .RESET_PC(64'h0)) dut (
      .clk              (clk),
      .rst              (rst),
      .fetchAddress     (fetchAddress),
      .fetchRequest     (fetchRequest),
      .fetchDone        (fetchDone),
      .fetchData        (fetchData),
      .redirectValid    (redirectValid),
      .redirectTarget   (redirectTarget),
      .fuWorking        (fuWorking),
      .instruction      (instruction),
      .bundleAddr       (bundleAddr),
      .instructionReady (instructionReady),
      .queueCount       (queueCount)
`ifdef FETCH_PERF_EN
      ,
      .perfStarveCount  (perfStarveCount)
`endif
   );

   always #5 clk = ~clk;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          cycle    = 0;
   int          last_disp = -100;
   int          n_disp   = 0;
   int          n_req    = 0;
   logic [63:0] sb[$];
   logic [63:0] model_pc = 64'h0;
   logic [63:0] mmu_addr = 64'h0;
   int          mmu_cnt  = 0;
   bit          mmu_stall = 1'b0;
   bit          mmu_drop  = 1'b0;

   function automatic logic [63:0] mk(input logic [63:0] a);
      return {a[31:0] ^ 32'hA5A5_0000, ~a[31:0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: observe outputs at negedge, run scoreboard and MMU model
   task automatic tick();
      logic [63:0] exp_a;
      @(negedge clk);
      cycle++;
      if (instructionReady === 1'b1) begin
         n_assert++;
         assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_dispatch: observed bundleAddr=%0h expected no dispatch", bundleAddr);
         end
         if (sb.size() != 0) begin
            exp_a = sb.pop_front();
            chk("dispatch_addr", bundleAddr, exp_a);
            chk("dispatch_data", instruction, mk(exp_a));
         end
         chk("dispatch_gap", 64'(cycle - last_disp >= 2), 64'd1);
         last_disp = cycle;
         n_disp++;
      end
      fetchDone = 1'b0;
      if (mmu_cnt != 0 && !mmu_stall) begin
         mmu_cnt--;
         if (mmu_cnt == 0) begin
            fetchDone = 1'b1;
            fetchData = mk(mmu_addr);
            if (mmu_drop) mmu_drop = 1'b0;
            else          sb.push_back(mmu_addr);
         end
      end
      if (fetchRequest === 1'b1) begin
         n_req++;
         chk("request_addr", fetchAddress, model_pc);
         mmu_addr = fetchAddress;
         mmu_cnt  = 2;
         model_pc = model_pc + 64'd8;
      end
   endtask

   task automatic run_until_disp(input string tag, input int target, input int budget);
      for (int k = 0; k < budget && n_disp < target; k++) tick();
      chk(tag, 64'(n_disp >= target), 64'd1);
   endtask

   task automatic wait_req(input string tag);
      bit got;
      got = 1'b0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (fetchRequest === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      chk(tag, 64'(got), 64'd1);
   endtask

   task automatic model_reset();
      mmu_cnt   = 0;
      mmu_drop  = 1'b0;
      sb.delete();
      model_pc  = 64'h0;
      last_disp = -100;
   endtask

   task automatic check_reset_values(input string pfx);
      chk({pfx, "_fetchAddress"}, fetchAddress, 64'h0);
      chk({pfx, "_fetchRequest"}, 64'(fetchRequest), 64'd0);
      chk({pfx, "_instrReady"}, 64'(instructionReady), 64'd0);
      chk({pfx, "_instruction"}, instruction, 64'h0);
      chk({pfx, "_bundleAddr"}, bundleAddr, 64'h0);
      chk({pfx, "_queueCount"}, 64'(queueCount), 64'd0);
`ifdef FETCH_PERF_EN
      chk({pfx, "_perf"}, 64'(perfStarveCount), 64'd0);
`endif
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no completion, expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int r0;
      logic [63:0] fa;
`ifdef FETCH_PERF_EN
      logic [31:0] p0;
`endif
      // Reset and first request
      rst = 1'b1;
      model_reset();
      tick();
      tick();
      check_reset_values("reset");
      rst = 1'b0;
      tick();
      chk("first_request", 64'(fetchRequest), 64'd1);

      // Streaming fetch/dispatch with idle FUs
      run_until_disp("stream_dispatch", 5, 120);

      // Busy FUs: queue fills to DEPTH, fetching stops
      fuWorking = 2'b11;
      rst = 1'b1;
      model_reset();
      tick();
      tick();
      rst = 1'b0;
      r0 = n_req;
      for (int k = 0; k < 30; k++) tick();
      chk("stall_req_count", 64'(n_req - r0), 64'd4);
      chk("stall_queueCount", 64'(queueCount), 64'd4);
      chk("stall_no_request", 64'(fetchRequest), 64'd0);
      fuWorking = 2'b00;
      run_until_disp("drain_dispatch", n_disp + 4, 60);

      // Redirect while a fetch is outstanding
      wait_req("redir_wait_req");
      sb.delete();
      redirectValid  = 1'b1;
      redirectTarget = 64'h1234;
      mmu_drop       = 1'b1;
      model_pc       = 64'h1230;
      tick();
      redirectValid = 1'b0;
      chk("redir_queueCount", 64'(queueCount), 64'd0);
      chk("redir_no_dispatch", 64'(instructionReady), 64'd0);
      wait_req("redir_next_req");
      chk("redir_fetchAddress", fetchAddress, 64'h1230);
      run_until_disp("redir_dispatch", n_disp + 1, 40);

      // Redirect coinciding with fetchDone and a pending dispatch
      fuWorking = 2'b11;
      begin
         bit hit;
         hit = 1'b0;
         for (int k = 0; k < 40; k++) begin
            tick();
            if (queueCount >= 3'd1 && fetchDone === 1'b1) begin
               hit = 1'b1;
               break;
            end
         end
         chk("coinc_setup", 64'(hit), 64'd1);
      end
      sb.delete();
      redirectValid  = 1'b1;
      redirectTarget = 64'h4000;
      fuWorking      = 2'b00;
      model_pc       = 64'h4000;
      tick();
      redirectValid = 1'b0;
      chk("coinc_no_dispatch", 64'(instructionReady), 64'd0);
      chk("coinc_queueCount", 64'(queueCount), 64'd0);
      wait_req("coinc_next_req");
      chk("coinc_fetchAddress", fetchAddress, 64'h4000);
      run_until_disp("coinc_dispatch", n_disp + 1, 40);

      // Reset mid-fetch with late responses during reset and at the first IDLE edge
      wait_req("rst_wait_req");
      rst = 1'b1;
      model_reset();
      fetchDone = 1'b1;
      fetchData = 64'hDEAD_BEEF_0BAD_F00D;
      tick();
      check_reset_values("midrst");
      rst = 1'b0;
      fetchDone = 1'b1;
      fetchData = 64'hDEAD_BEEF_0BAD_F00D;
      tick();
      chk("late_queueCount", 64'(queueCount), 64'd0);
      chk("late_request", 64'(fetchRequest), 64'd1);
      run_until_disp("late_dispatch", n_disp + 1, 40);

      // MMU stall with empty queue: address held, starvation counted
      rst = 1'b1;
      model_reset();
      mmu_stall = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      fa = fetchAddress;
      chk("stall_first_addr", fa, 64'h0);
`ifdef FETCH_PERF_EN
      p0 = perfStarveCount;
`endif
      for (int k = 0; k < 10; k++) tick();
      chk("stall_addr_held", fetchAddress, 64'h0);
      chk("stall_empty", 64'(queueCount), 64'd0);
      chk("stall_req_low", 64'(fetchRequest), 64'd0);
`ifdef FETCH_PERF_EN
      chk("perf_starve_delta", 64'(perfStarveCount), 64'(p0) + 64'd10);
`endif
      mmu_stall = 1'b0;
      run_until_disp("stall_dispatch", n_disp + 1, 40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
